// File: rtl/sha_pkg.sv
// Shared SHA round-constant tables and mode/round-count constants for the K sequencer.
package sha_pkg;

  localparam int MODE_SHA256   = 0;
  localparam int MODE_SHA512   = 1;
  localparam int ROUNDS_SHA256 = 64;
  localparam int ROUNDS_SHA512 = 80;
  localparam int ROUND_W       = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  function automatic int word_w(input int mode);
    return (mode == MODE_SHA512) ? 64 : 32;
  endfunction

  function automatic int rounds(input int mode);
    return (mode == MODE_SHA512) ? ROUNDS_SHA512 : ROUNDS_SHA256;
  endfunction

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage

// File: rtl/k_rom.sv
// Combinational round-constant lookup; MODE selects the SHA-256 or SHA-512 table.
module k_rom
  import sha_pkg::*;
#(
  parameter  int MODE   = MODE_SHA256,
  localparam int WORD_W = word_w(MODE)
) (
  input  logic [ROUND_W-1:0] idx,
  output logic [WORD_W-1:0]  k
);

  // Out-of-range indices return zero so the unused table tail is never read.
  if (MODE == MODE_SHA512) begin : g_512
    assign k = (idx < 7'(ROUNDS_SHA512)) ? K512[idx] : '0;
  end else begin : g_256
    assign k = (idx < 7'(ROUNDS_SHA256)) ? K256[idx[5:0]] : '0;
  end

endmodule

// File: rtl/k_constant_sequencer.sv
// Streams one registered K word per SHA round over Valid/Ready.
// Optional per-byte even-parity output enabled by defining K_SEQ_PARITY_EN.
//
// state   | meaning
// ST_IDLE | no block in progress; Valid/Busy low, waiting for Start
// ST_RUN  | presenting K[Round]; advances on each Valid&Ready handshake
module k_constant_sequencer
  import sha_pkg::*;
#(
  parameter  int MODE   = MODE_SHA256,
  localparam int WORD_W = word_w(MODE),
  localparam int ROUNDS = rounds(MODE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Ready,
  output logic               Valid,
  output logic [WORD_W-1:0]  K,
  output logic [ROUND_W-1:0] Round,
  output logic               Last,
  output logic               Busy,
`ifdef K_SEQ_PARITY_EN
  output logic [WORD_W/8-1:0] KParity,
`endif
  output logic               Done
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(ROUNDS - 1);

  seq_state_t         state_q, state_d;
  logic [ROUND_W-1:0] round_q, idx_d;
  logic [WORD_W-1:0]  k_q, rom_k;
  logic               done_q, done_d;
  logic               load, adv, clear;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    clear   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort outranks the handshake; Start is ignored throughout RUN.
        if (Abort) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else if (Ready) begin
          if (round_q == LAST_IDX) begin
            state_d = ST_IDLE;
            clear   = 1'b1;
            done_d  = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign idx_d = load ? '0 : round_q + 7'd1;

  k_rom #(.MODE(MODE)) u_k_rom (
    .idx (idx_d),
    .k   (rom_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load || adv) begin
        round_q <= idx_d;
        k_q     <= rom_k;
      end else if (clear) begin
        round_q <= '0;
        k_q     <= '0;
      end
    end
  end

`ifdef K_SEQ_PARITY_EN
  logic [WORD_W/8-1:0] par_q, par_d;

  always_comb begin
    par_d = '0;
    for (int i = 0; i < WORD_W/8; i++) par_d[i] = ^rom_k[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (load || adv) begin
      par_q <= par_d;
    end else if (clear) begin
      par_q <= '0;
    end
  end

  assign KParity = par_q;
`endif

  assign Valid = (state_q == ST_RUN);
  assign Busy  = (state_q == ST_RUN);
  assign K     = k_q;
  assign Round = round_q;
  assign Last  = Valid && (round_q == LAST_IDX);
  assign Done  = done_q;

endmodule

// File: tb/tb_k_constant_sequencer.sv
// Self-checking bench: SHA-256 and SHA-512 sequencers driven side by side against a round-level model.
module tb_k_constant_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, ready = 1'b0;

  logic        v0, l0, b0, d0, v1, l1, b1, d1;
  logic [31:0] k0;
  logic [63:0] k1;
  logic [6:0]  r0, r1;
`ifdef K_SEQ_PARITY_EN
  logic [3:0]  p0;
  logic [7:0]  p1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  k_constant_sequencer #(.MODE(0)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .Start(start), .Abort(abort), .Ready(ready),
    .Valid(v0), .K(k0), .Round(r0), .Last(l0), .Busy(b0),
`ifdef K_SEQ_PARITY_EN
    .KParity(p0),
`endif
    .Done(d0));

  k_constant_sequencer #(.MODE(1)) u_dut512 (
    .clk(clk), .rst_n(rst_n), .Start(start), .Abort(abort), .Ready(ready),
    .Valid(v1), .K(k1), .Round(r1), .Last(l1), .Busy(b1),
`ifdef K_SEQ_PARITY_EN
    .KParity(p1),
`endif
    .Done(d1));

  always #5 clk = ~clk;

  // Reference: K[i] is the fractional part of cbrt(prime_i), taken to 32 or 64 bits.
  logic [63:0] kref [2][80];
  int          nrounds [2] = '{64, 80};
  bit          m_busy [2];
  int          m_round [2];
  bit          m_done [2];
  int          n_done [2];
  int          n_acc  [2];

  function automatic logic [63:0] cbrt_frac(input int p, input int fb);
    logic [255:0] n, lo, hi, mid;
    n  = 256'(p) << (3 * fb);
    lo = '0;
    hi = 256'(1) << (fb + 3);
    while (lo < hi) begin
      mid = (lo + hi + 256'(1)) >> 1;
      if (mid * mid * mid <= n) lo = mid;
      else hi = mid - 256'(1);
    end
    return (fb == 32) ? {32'h0, lo[31:0]} : lo[63:0];
  endfunction

  task automatic build_tables();
    int cnt = 0;
    int c   = 2;
    while (cnt < 80) begin
      bit is_p = 1'b1;
      for (int d = 2; d * d <= c; d++) if (c % d == 0) is_p = 1'b0;
      if (is_p) begin
        kref[0][cnt] = (cnt < 64) ? cbrt_frac(c, 32) : 64'h0;
        kref[1][cnt] = cbrt_frac(c, 64);
        cnt++;
      end
      c++;
    end
  endtask

  function automatic logic [7:0] par_of(input logic [63:0] k, input int nbytes);
    logic [7:0] p = '0;
    for (int i = 0; i < nbytes; i++) p[i] = ^k[8*i +: 8];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input int i, input string tag, input logic v, input logic [63:0] k,
                           input logic [6:0] rd, input logic last, input logic busy, input logic done,
                           input logic [7:0] par);
    logic [63:0] ek;
    ek = m_busy[i] ? kref[i][m_round[i]] : 64'h0;
    chk($sformatf("%s_valid%0d", tag, i), 64'(v), 64'(m_busy[i]));
    chk($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'(m_busy[i]));
    chk($sformatf("%s_k%0d", tag, i), k, ek);
    chk($sformatf("%s_round%0d", tag, i), 64'(rd), m_busy[i] ? 64'(m_round[i]) : 64'h0);
    chk($sformatf("%s_last%0d", tag, i), 64'(last), 64'(m_busy[i] && m_round[i] == nrounds[i] - 1));
    chk($sformatf("%s_done%0d", tag, i), 64'(done), 64'(m_done[i]));
`ifdef K_SEQ_PARITY_EN
    chk($sformatf("%s_par%0d", tag, i), 64'(par), 64'(par_of(ek, (i == 0) ? 4 : 8)));
`else
    if (par != 8'h0) $display("note: parity argument unused in this build");
`endif
  endtask

  task automatic check_all(input string tag);
    logic [7:0] pp0 = '0, pp1 = '0;
`ifdef K_SEQ_PARITY_EN
    pp0 = {4'h0, p0};
    pp1 = p1;
`endif
    check_one(0, tag, v0, {32'h0, k0}, r0, l0, b0, d0, pp0);
    check_one(1, tag, v1, k1, r1, l1, b1, d1, pp1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_round[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit s, input bit a, input bit r);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (m_busy[i]) begin
        if (a) begin
          m_busy[i] = 1'b0; m_round[i] = 0;
        end else if (r) begin
          if (m_round[i] == nrounds[i] - 1) begin
            m_busy[i] = 1'b0; m_round[i] = 0; m_done[i] = 1'b1;
          end else begin
            m_round[i]++;
          end
        end
      end else if (s && !a) begin
        m_busy[i] = 1'b1; m_round[i] = 0;
      end
    end
  endtask

  task automatic step(input bit s, input bit a, input bit r, input string tag);
    start = s; abort = a; ready = r;
    if (v0 && r && !a) n_acc[0]++;
    if (v1 && r && !a) n_acc[1]++;
    @(posedge clk);
    model_edge(s, a, r);
    #1;
    if (d0) n_done[0]++;
    if (d1) n_done[1]++;
    check_all(tag);
  endtask

  initial begin
    build_tables();
    model_reset();
    chk("ref_k256_0",  kref[0][0],  64'h428a2f98);
    chk("ref_k256_63", kref[0][63], 64'hc67178f2);
    chk("ref_k512_0",  kref[1][0],  64'h428a2f98d728ae22);
    chk("ref_k512_79", kref[1][79], 64'h6c44198c4a475817);

    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Full block with Ready held high; a stray Start mid-block must be ignored.
    n_acc = '{0, 0}; n_done = '{0, 0};
    step(1, 0, 1, "full");
    chk("full_k256_r0", {32'h0, k0}, 64'h428a2f98);
    chk("full_k512_r0", k1, 64'h428a2f98d728ae22);
`ifdef K_SEQ_PARITY_EN
    chk("full_par256_r0", 64'(p0), 64'h7);
`endif
    for (int c = 1; c <= 63; c++) step(c == 40, 0, 1, "full");
    chk("full_k256_r63", {32'h0, k0}, 64'hc67178f2);
    chk("full_last256", 64'(l0), 64'h1);
    for (int c = 64; c <= 79; c++) step(0, 0, 1, "full");
    chk("full_k512_r79", k1, 64'h6c44198c4a475817);
    chk("full_last512", 64'(l1), 64'h1);
    step(0, 0, 1, "full");
    step(0, 0, 0, "full");
    chk("full_acc256", 64'(n_acc[0]), 64'd64);
    chk("full_acc512", 64'(n_acc[1]), 64'd80);
    chk("full_done256", 64'(n_done[0]), 64'd1);
    chk("full_done512", 64'(n_done[1]), 64'd1);

    // Stall at round 10, then abort at round 20 with Start and Ready also high.
    step(1, 0, 1, "stall");
    for (int c = 0; c < 10; c++) step(0, 0, 1, "stall");
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, "stall");
      chk("stall_k256", {32'h0, k0}, 64'h243185be);
      chk("stall_round", 64'(r0), 64'd10);
    end
    step(0, 0, 1, "stall");
    chk("stall_adv_k256", {32'h0, k0}, 64'h550c7dc3);
    for (int c = 0; c < 9; c++) step(0, 0, 1, "abort");
    chk("abort_round", 64'(r0), 64'd20);
    step(1, 1, 1, "abort");
    step(0, 0, 0, "abort");
    step(1, 0, 1, "restart");
    chk("restart_k256", {32'h0, k0}, 64'h428a2f98);

    // Asynchronous reset at round 30.
    for (int c = 0; c < 30; c++) step(0, 0, 1, "prerst");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 1, "postrst");
    step(1, 0, 1, "postrst");
    chk("postrst_round", 64'(r0), 64'd0);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
